// File: rtl/lru_ctrl_pkg.sv
// Shared constants for the LRU controller: table geometry, FSM state
// encodings and way encodings.
package lru_ctrl_pkg;

    // Table geometry: one LRU bit per set.
    localparam int CACHE_IDX_W = 8;
    localparam int CACHE_DEPTH = 1 << CACHE_IDX_W;

    // Controller states.
    typedef enum logic [1:0] {
        LRU_ST_INIT = 2'd0,
        LRU_ST_IDLE = 2'd1,
        LRU_ST_VUPD = 2'd2
    } lru_state_t;

    // Way encodings; the stored bit names the way to evict next.
    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

endpackage

// File: rtl/lru_ctrl.sv
// Read-modify-write controller for the 1-bit-per-set LRU table of a 2-way
// set-associative cache. Clears the table after reset, applies hit updates
// and answers victim queries (read, then mark the refilled way as MRU).
// Optional feature: define LRU_FLUSH_EN to add flush_i, which re-runs the
// table clear from IDLE or VUPD.
module lru_ctrl
    import lru_ctrl_pkg::*;
#(
    parameter int IDX_W = CACHE_IDX_W,
    parameter int DEPTH = CACHE_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LRU_FLUSH_EN
    input  logic             flush_i,
`endif
    output logic             init_done_o,
    input  logic             hit_valid_i,
    input  logic [IDX_W-1:0] hit_index_i,
    input  logic             hit_way_i,
    output logic             hit_ready_o,
    input  logic             vic_req_i,
    input  logic [IDX_W-1:0] vic_index_i,
    output logic             vic_ready_o,
    output logic             vic_valid_o,
    output logic             vic_way_o,
    output logic [IDX_W-1:0] lru_index_o,
    output logic             lru_wr_en_o,
    output logic             lru_wr_data_o,
    input  logic             lru_rd_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    lru_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] vic_idx_q, vic_idx_d;

    // State, clear-sweep counter and pending victim set.
    // NOTE: non-blocking assignments so every register updates from the same
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LRU_ST_INIT;
            cnt_q     <= '0;
            vic_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vic_idx_q <= vic_idx_d;
        end
    end

    // Next-state logic and all table-side / requester-side outputs.
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        vic_idx_d     = vic_idx_q;
        init_done_o   = 1'b0;
        hit_ready_o   = 1'b0;
        vic_ready_o   = 1'b0;
        vic_valid_o   = 1'b0;
        vic_way_o     = WAY0;
        lru_index_o   = '0;
        lru_wr_en_o   = 1'b0;
        lru_wr_data_o = 1'b0;

        unique case (state_q)
            LRU_ST_INIT: begin
                // Clear one set per cycle; the counter wraps back to 0.
                lru_index_o = cnt_q;
                lru_wr_en_o = 1'b1;
                cnt_d       = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = LRU_ST_IDLE;
                end
            end

            LRU_ST_IDLE: begin
                init_done_o = 1'b1;
                hit_ready_o = 1'b1;
                // Hits win the shared index port; a query waits a cycle.
                vic_ready_o = !hit_valid_i;
                if (hit_valid_i) begin
                    lru_index_o   = hit_index_i;
                    lru_wr_en_o   = 1'b1;
                    lru_wr_data_o = ~hit_way_i;
                end else if (vic_req_i) begin
                    lru_index_o = vic_index_i;
                    vic_idx_d   = vic_index_i;
                    state_d     = LRU_ST_VUPD;
                end
            end

            LRU_ST_VUPD: begin
                // Read data for the queried set arrives now: report it and
                // make the other way the next victim.
                init_done_o   = 1'b1;
                vic_valid_o   = 1'b1;
                vic_way_o     = (lru_rd_i == WAY1) ? WAY1 : WAY0;
                lru_index_o   = vic_idx_q;
                lru_wr_en_o   = 1'b1;
                lru_wr_data_o = ~lru_rd_i;
                state_d       = LRU_ST_IDLE;
            end

            default: begin
                state_d = LRU_ST_INIT;
                cnt_d   = '0;
            end
        endcase

`ifdef LRU_FLUSH_EN
        // Flush restarts the clear sweep; the current cycle's outputs
        // (including a VUPD write and result pulse) still complete.
        if (flush_i && (state_q != LRU_ST_INIT)) begin
            state_d = LRU_ST_INIT;
            cnt_d   = '0;
        end
`endif
    end

endmodule

// File: tb/tb_lru_ctrl.sv
// Directed self-checking bench for lru_ctrl with a behavioural model of the
// external 1-bit LRU table (registered read, read-before-write).
// Optional feature: LRU_FLUSH_EN enables the flush test.
module tb_lru_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
`ifdef LRU_FLUSH_EN
    logic       flush = 1'b0;
`endif
    logic       init_done;
    logic       hit_valid = 1'b0;
    logic [7:0] hit_index = '0;
    logic       hit_way   = 1'b0;
    logic       hit_ready;
    logic       vic_req   = 1'b0;
    logic [7:0] vic_index = '0;
    logic       vic_ready;
    logic       vic_valid;
    logic       vic_way;
    logic [7:0] lru_index;
    logic       lru_wr_en;
    logic       lru_wr_data;
    logic       lru_rd = 1'b0;

    int passed = 0;
    int total  = 0;

    logic mem [0:255];

    always #5 clk = ~clk;

    lru_ctrl dut (
        .clk           (clk),
        .rst           (rst),
`ifdef LRU_FLUSH_EN
        .flush_i       (flush),
`endif
        .init_done_o   (init_done),
        .hit_valid_i   (hit_valid),
        .hit_index_i   (hit_index),
        .hit_way_i     (hit_way),
        .hit_ready_o   (hit_ready),
        .vic_req_i     (vic_req),
        .vic_index_i   (vic_index),
        .vic_ready_o   (vic_ready),
        .vic_valid_o   (vic_valid),
        .vic_way_o     (vic_way),
        .lru_index_o   (lru_index),
        .lru_wr_en_o   (lru_wr_en),
        .lru_wr_data_o (lru_wr_data),
        .lru_rd_i      (lru_rd)
    );

    // External LRU table: registered read of the presented index, write on wr_en.
    always @(posedge clk) begin
        lru_rd <= mem[lru_index];
        if (lru_wr_en) mem[lru_index] <= lru_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Follow a full clear sweep starting at cnt=0, then expect IDLE.
    task automatic run_sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            #1;
            // {init_done, wr_en, index, data}
            check(tag, {init_done, lru_wr_en, lru_index, lru_wr_data},
                  {1'b0, 1'b1, 8'(i), 1'b0});
            cycle();
        end
        #1;
        check({tag, "_done"}, {init_done, lru_wr_en, hit_ready}, {1'b1, 1'b0, 1'b1});
    endtask

    initial begin
        // Table contents start dirty so the clear sweep is observable.
        for (int i = 0; i < 256; i++) mem[i] = 1'b1;

        // ---- Reset state ----
        cycle();
        cycle();
        check("rst_outs",
              {init_done, hit_ready, vic_ready, vic_valid, vic_way, lru_wr_en, lru_index, lru_wr_data},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0});

        // ---- Sweep after reset release ----
        rst = 1'b0;
        run_sweep("sweep1");

        // ---- Victim query to a cleared set returns way0 ----
        vic_req = 1'b1; vic_index = 8'h5A;
        #1;
        check("q5a_accept", {vic_ready, lru_wr_en, lru_index}, {1'b1, 1'b0, 8'h5A});
        cycle();
        vic_req = 1'b0;
        #1;
        check("q5a_result", {vic_valid, vic_way, hit_ready, vic_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("q5a_upd", {lru_wr_en, lru_index, lru_wr_data}, {1'b1, 8'h5A, 1'b1});
        cycle();
        check("q5a_pulse_end", {vic_valid, init_done}, {1'b0, 1'b1});

        // ---- Hit set 0x10 way0, then query it the next cycle ----
        hit_valid = 1'b1; hit_index = 8'h10; hit_way = 1'b0;
        #1;
        check("hit10", {hit_ready, vic_ready, lru_wr_en, lru_index, lru_wr_data},
              {1'b1, 1'b0, 1'b1, 8'h10, 1'b1});
        cycle();
        hit_valid = 1'b0; vic_req = 1'b1; vic_index = 8'h10;
        #1;
        check("q10_accept", vic_ready, 1'b1);
        cycle();
        vic_req = 1'b0;
        #1;
        check("q10_result", {vic_valid, vic_way}, {1'b1, 1'b1});
        check("q10_upd", {lru_wr_en, lru_index, lru_wr_data}, {1'b1, 8'h10, 1'b0});
        cycle();

        // ---- Hit and query collide: hit served, query waits ----
        hit_valid = 1'b1; hit_index = 8'h20; hit_way = 1'b0;
        vic_req = 1'b1; vic_index = 8'h30;
        #1;
        check("coll_hit", {hit_ready, vic_ready, lru_wr_en, lru_index, lru_wr_data},
              {1'b1, 1'b0, 1'b1, 8'h20, 1'b1});
        cycle();
        hit_valid = 1'b0;
        #1;
        check("coll_accept", {vic_ready, lru_wr_en, lru_index}, {1'b1, 1'b0, 8'h30});
        cycle();
        vic_req = 1'b0;
        #1;
        check("coll_result", {vic_valid, vic_way, lru_index}, {1'b1, 1'b0, 8'h30});
        cycle();
        // The hit to 0x20 way0 must have made way1 the victim.
        vic_req = 1'b1; vic_index = 8'h20;
        cycle();
        vic_req = 1'b0;
        #1;
        check("q20_result", {vic_valid, vic_way}, {1'b1, 1'b1});
        cycle();

        // ---- Back-to-back queries to 0x03 with the request held ----
        vic_req = 1'b1; vic_index = 8'h03;
        #1;
        check("q03a_accept", vic_ready, 1'b1);
        cycle();
        check("q03a_result", {vic_valid, vic_way, hit_ready, vic_ready}, {1'b1, 1'b0, 1'b0, 1'b0});
        cycle();
        check("q03b_accept", {vic_valid, vic_ready}, {1'b0, 1'b1});
        cycle();
        vic_req = 1'b0;
        #1;
        check("q03b_result", {vic_valid, vic_way, hit_ready}, {1'b1, 1'b1, 1'b0});
        cycle();

        // ---- Back-to-back hits, then read both sets back ----
        hit_valid = 1'b1; hit_index = 8'h40; hit_way = 1'b1;
        #1;
        check("hit40", {hit_ready, lru_wr_en, lru_wr_data}, {1'b1, 1'b1, 1'b0});
        cycle();
        hit_index = 8'h41; hit_way = 1'b0;
        #1;
        check("hit41", {hit_ready, lru_wr_en, lru_index, lru_wr_data}, {1'b1, 1'b1, 8'h41, 1'b1});
        cycle();
        hit_valid = 1'b0; vic_req = 1'b1; vic_index = 8'h41;
        cycle();
        vic_req = 1'b0;
        #1;
        check("q41_result", {vic_valid, vic_way}, {1'b1, 1'b1});
        cycle();

        // ---- Reset at sweep cycle 100 restarts the sweep ----
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) cycle();
        #1;
        check("mid_sweep_idx", {lru_wr_en, lru_index, init_done}, {1'b1, 8'd100, 1'b0});
        rst = 1'b1;
        #1;
        check("mid_rst_idx", {lru_wr_en, lru_index, init_done}, {1'b1, 8'h00, 1'b0});
        cycle();
        rst = 1'b0;
        run_sweep("sweep2");
        // The restarted sweep must have cleared 0x41 again.
        vic_req = 1'b1; vic_index = 8'h41;
        cycle();
        vic_req = 1'b0;
        #1;
        check("q41_cleared", {vic_valid, vic_way}, {1'b1, 1'b0});
        cycle();

`ifdef LRU_FLUSH_EN
        // ---- Flush in IDLE re-clears the table ----
        hit_valid = 1'b1; hit_index = 8'hFF; hit_way = 1'b0;
        cycle();
        hit_valid = 1'b0; flush = 1'b1;
        #1;
        check("flush_taken_cycle", init_done, 1'b1);
        cycle();
        flush = 1'b0;
        run_sweep("sweep_flush");
        vic_req = 1'b1; vic_index = 8'hFF;
        cycle();
        vic_req = 1'b0;
        #1;
        check("qff_after_flush", {vic_valid, vic_way}, {1'b1, 1'b0});
        cycle();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
